rsa_modexp_seq: RTL

- Parametrised modular-exponentiation sequencer that computes result = X^E mod N.
- It runs the full Montgomery-domain flow autonomously: to-Montgomery conversion, left-to-right square-and-multiply over the exponent bits, then from-Montgomery conversion.
- It drives one external montgomery multiplier through a start/done handshake, so software no longer issues one command per multiplication.
- It sits between the rsa command/DMA wrapper (operand source) and the montgomery core.

---
 rtl/rsa_modexp_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/rsa_modexp_seq.sv
// ---------------------------------------------------------------------------
// rsa_modexp_seq
//
// Computes result = X^E mod N with an external Montgomery multiplier. The
// whole flow runs without software help: X is converted into the Montgomery
// domain, the exponent is scanned MSB-first with square-and-multiply, and
// the accumulator is finally converted back out of the Montgomery domain.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   start                one-cycle request; x_in/n_in/r2n_in/rn_in/e_in/e_len
//                        are sampled on it
//   x_in, n_in           base (X < N) and odd modulus
//   r2n_in, rn_in        R^2 mod N and R mod N, with R = 2^WIDTH
//   e_in, e_len          exponent and number of its low bits to process
//   busy                 run in progress
//   done, error          completion pulse; error marks a rejected request
//   result               X^E mod N, held until the next accepted start
//   mul_count            multiplications issued in the current/last run
//   mm_start/mm_a/mm_b/mm_m   request to the Montgomery core
//   mm_result/mm_done    response from the Montgomery core
// ---------------------------------------------------------------------------
module rsa_modexp_seq #(
    parameter int WIDTH     = 1024,
    parameter int EXP_WIDTH = 1024,
    parameter int LEN_W     = 11
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x_in,
    input  logic [WIDTH-1:0]     n_in,
    input  logic [WIDTH-1:0]     r2n_in,
    input  logic [WIDTH-1:0]     rn_in,
    input  logic [EXP_WIDTH-1:0] e_in,
    input  logic [LEN_W-1:0]     e_len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     result,
    output logic [15:0]          mul_count,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH-1:0]     mm_result,
    input  logic                 mm_done
);

    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [LEN_W:0] EXP_MAX = (LEN_W+1)'(EXP_WIDTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TO_MONT   = 3'd1;
    localparam logic [2:0] S_SQUARE    = 3'd2;
    localparam logic [2:0] S_MULT      = 3'd3;
    localparam logic [2:0] S_FROM_MONT = 3'd4;
    localparam logic [2:0] S_FINISH    = 3'd5;

    logic [2:0]           r_state;
    logic                 r_wait;      // an op has been issued, waiting for mm_done
    logic                 r_err;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_n;
    logic [WIDTH-1:0]     r_r2n;
    logic [EXP_WIDTH-1:0] r_e;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_i;
    logic [WIDTH-1:0]     r_a;         // Montgomery-domain accumulator
    logic [WIDTH-1:0]     r_xt;        // X in the Montgomery domain
    logic [WIDTH-1:0]     r_result;
    logic [15:0]          r_mul_count;

    logic w_op_state;
    logic w_issue;
    logic w_fire;
    logic w_ebit;
    logic w_i_zero;

    assign w_op_state = (r_state == S_TO_MONT) || (r_state == S_SQUARE) ||
                        (r_state == S_MULT)    || (r_state == S_FROM_MONT);
    // First cycle of every op state issues; mm_done only counts while waiting,
    // so a stray pulse in IDLE/FINISH or before issue has no effect.
    assign w_issue    = w_op_state && !r_wait;
    assign w_fire     = w_op_state && r_wait && mm_done;
    assign w_ebit     = r_e[r_i[IDX_W-1:0]];
    assign w_i_zero   = (r_i == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_wait      <= 1'b0;
            r_err       <= 1'b0;
            r_x         <= '0;
            r_n         <= '0;
            r_r2n       <= '0;
            r_e         <= '0;
            r_len       <= '0;
            r_i         <= '0;
            r_a         <= '0;
            r_xt        <= '0;
            r_result    <= '0;
            r_mul_count <= '0;
        end else begin
            if (w_issue) begin
                r_wait      <= 1'b1;
                r_mul_count <= r_mul_count + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mul_count <= '0;
                        if ({1'b0, e_len} > EXP_MAX) begin
                            r_err   <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_err   <= 1'b0;
                            r_x     <= x_in;
                            r_n     <= n_in;
                            r_r2n   <= r2n_in;
                            r_e     <= e_in;
                            r_len   <= e_len;
                            r_a     <= rn_in;   // Montgomery form of 1
                            r_i     <= e_len - 1'b1;
                            r_state <= S_TO_MONT;
                        end
                    end
                end
                S_TO_MONT: begin
                    if (w_fire) begin
                        r_xt    <= mm_result;
                        r_wait  <= 1'b0;
                        r_state <= (r_len != '0) ? S_SQUARE : S_FROM_MONT;
                    end
                end
                S_SQUARE: begin
                    if (w_fire) begin
                        r_a    <= mm_result;
                        r_wait <= 1'b0;
                        if (w_ebit) begin
                            r_state <= S_MULT;
                        end else if (w_i_zero) begin
                            r_state <= S_FROM_MONT;
                        end else begin
                            r_i     <= r_i - 1'b1;
                            r_state <= S_SQUARE;
                        end
                    end
                end
                S_MULT: begin
                    if (w_fire) begin
                        r_a    <= mm_result;
                        r_wait <= 1'b0;
                        if (w_i_zero) begin
                            r_state <= S_FROM_MONT;
                        end else begin
                            r_i     <= r_i - 1'b1;
                            r_state <= S_SQUARE;
                        end
                    end
                end
                S_FROM_MONT: begin
                    if (w_fire) begin
                        r_result <= mm_result;
                        r_wait   <= 1'b0;
                        r_state  <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Operands are pure functions of state and registers that only change on
    // w_fire, so they stay stable for the whole wait.
    always_comb begin
        mm_a = r_a;
        mm_b = '0;
        case (r_state)
            S_TO_MONT:   begin mm_a = r_x; mm_b = r_r2n; end
            S_SQUARE:    mm_b = r_a;
            S_MULT:      mm_b = r_xt;
            S_FROM_MONT: mm_b = WIDTH'(1);
            default:     mm_b = '0;
        endcase
    end

    assign mm_start  = w_issue;
    assign mm_m      = r_n;
    assign busy      = w_op_state;
    assign done      = (r_state == S_FINISH);
    assign error     = (r_state == S_FINISH) && r_err;
    assign result    = r_result;
    assign mul_count = r_mul_count;

endmodule
